// File: rtl/bin_to_hex_pkg.sv
// Shared constants and the digit-count helper for the binary-to-BCD converter.
// Pure declarations: no logic, no latency, no flow control.
package bin_to_hex_pkg;

  localparam int BCD_W   = 4;
  localparam int BCD_MAX = 9;
  // A nibble at or above this value overflows past 9 once doubled.
  localparam int BCD_ADJ_THRESH = (BCD_MAX + 1) / 2;

  // Fewest decimal digits that can hold 2^width - 1.
  function automatic int ndig_for(input int width);
    longint maxv;
    longint pow10;
    int     n;
    maxv  = (longint'(1) << width) - 1;
    pow10 = 10;
    n     = 1;
    for (int k = 0; k < 8; k++) begin
      if (pow10 <= maxv) begin
        n     = n + 1;
        pow10 = pow10 * 10;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/bin_to_hex_add3.sv
// Double-dabble correction cell: adds 3 to a BCD nibble of 5 or more.
// Purely combinational, no latency, no flow control.
module bcd_add3
  import bin_to_hex_pkg::*;
(
  input  logic [BCD_W-1:0] din,
  output logic [BCD_W-1:0] dout
);

  always_comb begin
    dout = din;
    if (din >= BCD_W'(BCD_ADJ_THRESH)) begin
      dout = din + BCD_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_hex.sv
// Binary-to-packed-BCD converter: combinational shift-add-3 grid, registered output.
// Latency 1 cycle; no backpressure, a new value is accepted every cycle.
module bin_to_hex
  import bin_to_hex_pkg::*;
#(
  parameter int IN_W = 4,
  parameter int NDIG = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IN_W-1:0]       NUMBER,
  output logic [BCD_W*NDIG-1:0] DIGITS
);

  localparam int FW = BCD_W * NDIG;

  if (IN_W < 1 || IN_W > 16) begin : g_bad_width
    $error("bin_to_hex: IN_W must lie in 1..16");
  end
  if (NDIG < ndig_for(IN_W)) begin : g_bad_ndig
    $error("bin_to_hex: NDIG too small to hold 2^IN_W - 1");
  end

  // field[i] is the BCD field after i input bits have been shifted in.
  logic [FW-1:0]   field [0:IN_W];
  logic [FW-1:0]   adj   [0:IN_W-1];
  logic [IN_W-1:0] carry;

  assign field[0] = '0;

  for (genvar i = 0; i < IN_W; i++) begin : g_iter
    for (genvar d = 0; d < NDIG; d++) begin : g_dig
      bcd_add3 u_cell (
        .din  (field[i][d*BCD_W +: BCD_W]),
        .dout (adj[i][d*BCD_W +: BCD_W])
      );
    end
    assign {carry[i], field[i+1]} = {adj[i], NUMBER[IN_W-1-i]};
  end

  // The digit-count check makes a bit falling off the top impossible.
  always_comb begin : carry_chk
    assert (carry == '0);
  end

  logic [FW-1:0] digits_d;
  logic [FW-1:0] digits_q;

  always_comb begin
    digits_d = field[IN_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits_q <= '0;
    end else begin
      digits_q <= digits_d;
    end
  end

  assign DIGITS = digits_q;

endmodule

// File: tb/tb_bin_to_hex.sv
// Self-checking bench for bin_to_hex: default 4-bit/2-digit instance plus an 8-bit/3-digit variant.
module tb_bin_to_hex;

  logic        clk;
  logic        rst_n;
  logic [3:0]  number_s;
  logic [7:0]  digits_s;
  logic [7:0]  number_w;
  logic [11:0] digits_w;

  int n_cmp;
  int n_bad;

  bin_to_hex #(.IN_W(4), .NDIG(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .NUMBER (number_s),
    .DIGITS (digits_s)
  );

  bin_to_hex #(.IN_W(8), .NDIG(3)) dut_w (
    .clk    (clk),
    .rst_n  (rst_n),
    .NUMBER (number_w),
    .DIGITS (digits_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] num;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [13];

  // Decimal digits by repeated division, one nibble per digit.
  function automatic logic [31:0] ref_bcd(input int unsigned v);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic nib_ok(input logic [31:0] x);
    for (int k = 0; k < 8; k++) begin
      if (x[4*k +: 4] > 4'd9) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    number_s = 4'd7;
    number_w = 8'd200;

    vecs[0]  = '{4'd0,  8'h00};
    vecs[1]  = '{4'd1,  8'h01};
    vecs[2]  = '{4'd2,  8'h02};
    vecs[3]  = '{4'd3,  8'h03};
    vecs[4]  = '{4'd4,  8'h04};
    vecs[5]  = '{4'd5,  8'h05};
    vecs[6]  = '{4'd6,  8'h06};
    vecs[7]  = '{4'd7,  8'h07};
    vecs[8]  = '{4'd8,  8'h08};
    vecs[9]  = '{4'd9,  8'h09};
    vecs[10] = '{4'd10, 8'h10};
    vecs[11] = '{4'd11, 8'h11};
    vecs[12] = '{4'd15, 8'h15};

    // Reset held across several edges with a nonzero input.
    #1;
    check("reset_initial", 32'(digits_s), 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("reset_hold", 32'(digits_s), 32'h0);
      check("reset_hold_w", 32'(digits_w), 32'h0);
    end
    rst_n = 1'b1;

    // Table sweep: each value appears one edge after it is driven.
    for (int i = 0; i < 13; i++) begin
      number_s = vecs[i].num;
      step();
      check("table", 32'(digits_s), 32'(vecs[i].exp));
      check("table_nibbles", 32'(nib_ok(32'(digits_s))), 32'h1);
    end

    // Input wiggles between edges; only the sampled value may appear.
    number_s = 4'd3;
    #2 number_s = 4'd12;
    #2 number_s = 4'd5;
    check("glitch_hold", 32'(digits_s), 32'h15);
    step();
    check("glitch_sampled", 32'(digits_s), 32'h05);

    // Stream 0..15 with a half-cycle asynchronous reset pulse at 8.
    for (int v = 0; v < 16; v++) begin
      number_s = 4'(v);
      if (v == 8) begin
        #2 rst_n = 1'b0;
        #1 check("midrun_async_clear", 32'(digits_s), 32'h0);
        #1 rst_n = 1'b1;
      end
      step();
      check("midrun_stream", 32'(digits_s), ref_bcd(v));
    end

    // Wide variant boundaries.
    number_w = 8'd255;
    step();
    check("wide_255", 32'(digits_w), 32'h255);
    number_w = 8'd100;
    step();
    check("wide_100", 32'(digits_w), 32'h100);
    number_w = 8'd0;
    step();
    check("wide_0", 32'(digits_w), 32'h0);

    // Randomized traffic on both instances against the arithmetic model.
    for (int k = 0; k < 300; k++) begin
      logic [3:0] a;
      logic [7:0] b;
      a = 4'($urandom_range(0, 15));
      b = 8'($urandom_range(0, 255));
      number_s = a;
      number_w = b;
      step();
      check("rand_narrow", 32'(digits_s), ref_bcd(a));
      check("rand_wide", 32'(digits_w), ref_bcd(b));
      check("rand_nibbles", 32'(nib_ok({20'h0, digits_w})), 32'h1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bin_to_hex.md
Name: bin_to_hex

Overview:
- Clocked binary-to-BCD converter. Takes an unsigned binary value and produces its packed decimal digits, least-significant digit in the low nibble.
- Default configuration converts a 4-bit value (0..15) into two BCD digits (tens, ones).
- Sits between counter/datapath logic and the display-driver stage; output is registered so it can feed the display mux directly.

Parameters:
- IN_W, 4, width of the binary input NUMBER; legal range 1..16.
- NDIG, 2, number of BCD output digits. Must satisfy 10^NDIG > 2^IN_W - 1; an elaboration-time check fails otherwise.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- NUMBER  input  IN_W  unsigned binary value to convert; sampled every rising clk edge.
- DIGITS  output  4*NDIG  packed BCD result. DIGITS[3:0] = ones, DIGITS[7:4] = tens, and so on upward.

Behaviour:
- Reset: while rst_n = 0, DIGITS = 0 immediately, independent of clk. Release is synchronous in effect: the first load happens at the first rising edge with rst_n = 1.
- Conversion core:
  - Combinational shift-add-3 (double-dabble) over IN_W iterations on an NDIG-digit BCD field.
  - Each iteration: every digit >= 5 gets +3, then the field shifts left 1 with the next NUMBER bit, MSB first.
- Output register:
  - DIGITS loads the core result on every rising clk edge with rst_n = 1.
  - Latency is exactly 1 cycle: NUMBER sampled at edge k appears on DIGITS after edge k.
  - No enable and no handshake; one new conversion per cycle, full throughput.
- Every BCD nibble on DIGITS is always in range 0..9. Unused upper digits are 0.
- Defaults (IN_W=4, NDIG=2):
  - NUMBER 0..9 -> DIGITS = 8'h00..8'h09.
  - NUMBER 10..15 -> DIGITS = 8'h10..8'h15.
- NUMBER changing between edges has no effect on DIGITS until the next edge; there are no combinational paths from NUMBER to DIGITS.
- Reset asserted mid-stream clears DIGITS at once. The value of NUMBER present at the first post-reset edge is converted normally.
- Maximum input 2^IN_W - 1 converts without overflow; the parameter check guarantees this.

Decomposition:
- Shared package bin_to_hex_pkg:
  - BCD_W = 4 and BCD_MAX = 9.
  - Function ndig_for(width) returning the minimum digit count, used by the elaboration check.
- One natural sub-module: bcd_add3, a 4-bit combinational cell (in >= 5 ? in + 3 : in). The core instantiates it in a generate grid of IN_W by NDIG cells.
- Top level holds the generate grid, the parameter check and the output register.

Test Plan:
- Reset: hold rst_n = 0 with NUMBER = 4'd7 across several edges -> DIGITS = 8'h00 throughout. Assert rst_n asynchronously mid-cycle -> DIGITS clears before the next edge.
- Sweep: after reset, drive NUMBER = 0..9, one value per cycle -> DIGITS = 8'h00..8'h09, each one cycle after its input.
- Upper range: NUMBER = 10, 11, 15 -> DIGITS = 8'h10, 8'h11, 8'h15. Every nibble is <= 9 on every cycle.
- Latency/glitch: change NUMBER 3 -> 12 -> 5 between edges, with only 5 present at the sampling edge -> DIGITS goes straight to 8'h05 after that edge, with no intermediate value.
- Mid-run reset: stream 0..15, pulse rst_n low for half a cycle at value 8 -> DIGITS = 0 during reset, then resumes correct conversion from the next sampled NUMBER.
- Parameter variant: IN_W=8, NDIG=3, NUMBER = 8'd255 -> DIGITS = 12'h255. NUMBER = 8'd100 -> 12'h100. IN_W=8, NDIG=2 -> elaboration error.
